// File: rtl/lsb_queue.sv
`default_nettype none
// ============================================================================
// Module   : lsb_queue
// Brief    : In-order load/store queue with CDB snooping, commit-gated stores
//            and flush that preserves the committed-store prefix.
// Revision : 1.0 - initial release
// ============================================================================
module lsb_queue #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int NICK_W = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clr,
    input  logic                     iDP_en,
    input  logic [OP_W-1:0]          iDP_op,
    input  logic [DATA_W-1:0]        iDP_imm,
    input  logic [NICK_W-1:0]        iDP_rd_nick,
    input  logic [NICK_W-1:0]        iDP_rs1_nick,
    input  logic [NICK_W-1:0]        iDP_rs2_nick,
    input  logic [DATA_W-1:0]        iDP_rs1_dt,
    input  logic [DATA_W-1:0]        iDP_rs2_dt,
    input  logic [CDB_N-1:0]         iCDB_en,
    input  logic [CDB_N*NICK_W-1:0]  iCDB_nick,
    input  logic [CDB_N*DATA_W-1:0]  iCDB_dt,
    input  logic                     iROB_commit_en,
    input  logic [NICK_W-1:0]        iROB_commit_nick,
    output logic                     oDC_en,
    output logic                     oDC_ls,
    output logic [2:0]               oDC_len,
    output logic [ADDR_W-1:0]        oDC_addr,
    output logic [DATA_W-1:0]        oDC_dt,
    input  logic                     iDC_en,
    input  logic [DATA_W-1:0]        iDC_dt,
    output logic                     oLSB_en,
    output logic [NICK_W-1:0]        oLSB_nick,
    output logic [DATA_W-1:0]        oLSB_dt,
    output logic                     oFULL
);

    localparam int                  c_CNT_W  = IDX_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_ALMOST = c_CNT_W'(DEPTH - 1);

    localparam logic [OP_W-1:0] c_OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] c_OP_SW  = OP_W'(8);

    function automatic logic f_is_store(input logic [OP_W-1:0] op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    function automatic logic [2:0] f_len(input logic [OP_W-1:0] op);
        logic [2:0] len;
        if (op == c_OP_LB || op == c_OP_LBU || op == c_OP_SB)
            len = 3'd1;
        else if (op == c_OP_LH || op == c_OP_LHU || op == c_OP_SH)
            len = 3'd2;
        else
            len = 3'd4;
        return len;
    endfunction

    function automatic logic [DATA_W-1:0] f_extend(input logic [OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        if (op == c_OP_LB)
            r = {{(DATA_W-8){d[7]}}, d[7:0]};
        else if (op == c_OP_LBU)
            r = {{(DATA_W-8){1'b0}}, d[7:0]};
        else if (op == c_OP_LH)
            r = {{(DATA_W-16){d[15]}}, d[15:0]};
        else if (op == c_OP_LHU)
            r = {{(DATA_W-16){1'b0}}, d[15:0]};
        else
            r = d;
        return r;
    endfunction

    // Returns {hit, data}; the loop runs high-to-low so channel 0 wins,
    // and the internal broadcast is checked first so it ranks last.
    function automatic logic [DATA_W:0] f_snoop(
        input logic [NICK_W-1:0]        tag,
        input logic [CDB_N-1:0]         en,
        input logic [CDB_N*NICK_W-1:0]  nicks,
        input logic [CDB_N*DATA_W-1:0]  dts,
        input logic                     l_en,
        input logic [NICK_W-1:0]        l_nick,
        input logic [DATA_W-1:0]        l_dt
    );
        logic [DATA_W:0] res;
        res = '0;
        if (tag != '0) begin
            if (l_en && l_nick == tag)
                res = {1'b1, l_dt};
            for (int k = CDB_N - 1; k >= 0; k--) begin
                if (en[k] && nicks[k*NICK_W +: NICK_W] == tag)
                    res = {1'b1, dts[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    logic [DEPTH-1:0]   r_vld;
    logic [DEPTH-1:0]   r_cmt;
    logic [OP_W-1:0]    r_op   [DEPTH];
    logic [DATA_W-1:0]  r_imm  [DEPTH];
    logic [DATA_W-1:0]  r_v1   [DEPTH];
    logic [DATA_W-1:0]  r_v2   [DEPTH];
    logic [NICK_W-1:0]  r_nick [DEPTH];
    logic [NICK_W-1:0]  r_q1   [DEPTH];
    logic [NICK_W-1:0]  r_q2   [DEPTH];

    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_drop;

    logic               r_dc_en;
    logic               r_dc_ls;
    logic [2:0]         r_dc_len;
    logic [ADDR_W-1:0]  r_dc_addr;
    logic [DATA_W-1:0]  r_dc_dt;
    logic               r_lsb_en;
    logic [NICK_W-1:0]  r_lsb_nick;
    logic [DATA_W-1:0]  r_lsb_dt;
    logic               r_full;

    logic               w_head_st;
    logic               w_issue;
    logic               w_done;
    logic               w_pop;
    logic               w_bcast;
    logic               w_wr;
    logic [DATA_W-1:0]  w_sum;
    logic [DEPTH-1:0]   w_cmt;
    logic [DEPTH-1:0]   w_keep;
    logic [c_CNT_W-1:0] w_prefix;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [IDX_W-1:0]   w_head_nxt;
    logic [IDX_W-1:0]   w_tail_nxt;
    logic [DATA_W:0]    w_s1 [DEPTH];
    logic [DATA_W:0]    w_s2 [DEPTH];
    logic [DATA_W:0]    w_dp1;
    logic [DATA_W:0]    w_dp2;

    always_comb begin : p_ctrl
        w_head_st = f_is_store(r_op[r_head]);
        w_issue   = !clr && r_vld[r_head] && !r_busy && (r_q1[r_head] == '0) &&
                    (!w_head_st || ((r_q2[r_head] == '0) && r_cmt[r_head]));
        w_done    = r_busy && iDC_en;
        // A load completing in the flush cycle is already squashed.
        w_pop     = w_done && !r_drop && !(clr && !w_head_st);
        w_bcast   = w_pop && !w_head_st;
        w_wr      = iDP_en && !clr && (r_count != c_DEPTH);
        w_sum     = r_v1[r_head] + r_imm[r_head];
        w_dp1     = f_snoop(iDP_rs1_nick, iCDB_en, iCDB_nick, iCDB_dt,
                            r_lsb_en, r_lsb_nick, r_lsb_dt);
        w_dp2     = f_snoop(iDP_rs2_nick, iCDB_en, iCDB_nick, iCDB_dt,
                            r_lsb_en, r_lsb_nick, r_lsb_dt);
        for (int i = 0; i < DEPTH; i++) begin
            w_cmt[i] = r_cmt[i] | (r_vld[i] && iROB_commit_en &&
                       (iROB_commit_nick == r_nick[i]) && f_is_store(r_op[i]));
            w_s1[i]  = f_snoop(r_q1[i], iCDB_en, iCDB_nick, iCDB_dt,
                               r_lsb_en, r_lsb_nick, r_lsb_dt);
            w_s2[i]  = f_snoop(r_q2[i], iCDB_en, iCDB_nick, iCDB_dt,
                               r_lsb_en, r_lsb_nick, r_lsb_dt);
        end
    end

    // Length of the committed-store run starting at head, and which slots it covers.
    always_comb begin : p_prefix
        logic             run;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] off;
        w_prefix = '0;
        run      = 1'b1;
        idx      = '0;
        off      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = r_head + IDX_W'(j);
            if (run && r_vld[idx] && w_cmt[idx] && f_is_store(r_op[idx]))
                w_prefix = w_prefix + c_CNT_W'(1);
            else
                run = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            off       = IDX_W'(i) - r_head;
            w_keep[i] = ({1'b0, off} < w_prefix);
        end
    end

    always_comb begin : p_next
        w_head_nxt = r_head + {{(IDX_W-1){1'b0}}, w_pop};
        if (clr) begin
            w_tail_nxt  = r_head + w_prefix[IDX_W-1:0];
            w_count_nxt = w_prefix - {{IDX_W{1'b0}}, w_pop};
        end else begin
            w_tail_nxt  = r_tail + {{(IDX_W-1){1'b0}}, w_wr};
            w_count_nxt = r_count + {{IDX_W{1'b0}}, w_wr} - {{IDX_W{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            r_vld      <= '0;
            r_cmt      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_dc_en    <= 1'b0;
            r_dc_ls    <= 1'b0;
            r_dc_len   <= '0;
            r_dc_addr  <= '0;
            r_dc_dt    <= '0;
            r_lsb_en   <= 1'b0;
            r_lsb_nick <= '0;
            r_lsb_dt   <= '0;
            r_full     <= 1'b0;
        end else if (rdy) begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= c_ALMOST);

            if (w_done)
                r_busy <= 1'b0;
            else if (w_issue)
                r_busy <= 1'b1;

            if (w_done)
                r_drop <= 1'b0;
            else if (clr && r_busy && !w_head_st)
                r_drop <= 1'b1;

            for (int i = 0; i < DEPTH; i++) begin
                r_cmt[i] <= w_cmt[i];
                if (clr && !w_keep[i]) begin
                    r_vld[i] <= 1'b0;
                    r_cmt[i] <= 1'b0;
                end
                if (w_pop && IDX_W'(i) == r_head) begin
                    r_vld[i] <= 1'b0;
                    r_cmt[i] <= 1'b0;
                end
                if (w_wr && IDX_W'(i) == r_tail) begin
                    r_vld[i] <= 1'b1;
                    r_cmt[i] <= 1'b0;
                end
            end

            r_dc_en    <= w_issue;
            r_dc_ls    <= w_issue && w_head_st;
            r_dc_len   <= w_issue ? f_len(r_op[r_head]) : 3'd0;
            r_dc_addr  <= w_issue ? ADDR_W'(w_sum) : '0;
            r_dc_dt    <= (w_issue && w_head_st) ? r_v2[r_head] : '0;
            r_lsb_en   <= w_bcast;
            r_lsb_nick <= w_bcast ? r_nick[r_head] : '0;
            r_lsb_dt   <= w_bcast ? f_extend(r_op[r_head], iDC_dt) : '0;
        end else begin
            r_dc_en  <= 1'b0;
            r_lsb_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : p_entries
        if (!rst && rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && w_s1[i][DATA_W]) begin
                    r_q1[i] <= '0;
                    r_v1[i] <= w_s1[i][DATA_W-1:0];
                end
                if (r_vld[i] && w_s2[i][DATA_W]) begin
                    r_q2[i] <= '0;
                    r_v2[i] <= w_s2[i][DATA_W-1:0];
                end
                if (w_wr && IDX_W'(i) == r_tail) begin
                    r_op[i]   <= iDP_op;
                    r_imm[i]  <= iDP_imm;
                    r_nick[i] <= iDP_rd_nick;
                    r_q1[i]   <= w_dp1[DATA_W] ? '0 : iDP_rs1_nick;
                    r_v1[i]   <= w_dp1[DATA_W] ? w_dp1[DATA_W-1:0] : iDP_rs1_dt;
                    r_q2[i]   <= w_dp2[DATA_W] ? '0 : iDP_rs2_nick;
                    r_v2[i]   <= w_dp2[DATA_W] ? w_dp2[DATA_W-1:0] : iDP_rs2_dt;
                end
            end
        end
    end

    assign oDC_en    = r_dc_en;
    assign oDC_ls    = r_dc_ls;
    assign oDC_len   = r_dc_len;
    assign oDC_addr  = r_dc_addr;
    assign oDC_dt    = r_dc_dt;
    assign oLSB_en   = r_lsb_en;
    assign oLSB_nick = r_lsb_nick;
    assign oLSB_dt   = r_lsb_dt;
    assign oFULL     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_lsb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsb_queue
// Brief    : Directed self-checking bench for lsb_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsb_queue;

    localparam logic [5:0] OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3, OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5, OP_SW = 6'd8;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
    logic        iDP_en = 1'b0;
    logic [5:0]  iDP_op = '0;
    logic [31:0] iDP_imm = '0, iDP_rs1_dt = '0, iDP_rs2_dt = '0;
    logic [3:0]  iDP_rd_nick = '0, iDP_rs1_nick = '0, iDP_rs2_nick = '0;
    logic [1:0]  iCDB_en = '0;
    logic [7:0]  iCDB_nick = '0;
    logic [63:0] iCDB_dt = '0;
    logic        iROB_commit_en = 1'b0;
    logic [3:0]  iROB_commit_nick = '0;
    logic        oDC_en, oDC_ls;
    logic [2:0]  oDC_len;
    logic [31:0] oDC_addr, oDC_dt;
    logic        iDC_en = 1'b0;
    logic [31:0] iDC_dt = '0;
    logic        oLSB_en;
    logic [3:0]  oLSB_nick;
    logic [31:0] oLSB_dt;
    logic        oFULL;

    int checks = 0;
    int failures = 0;

    lsb_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_imm(iDP_imm), .iDP_rd_nick(iDP_rd_nick),
        .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick),
        .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
        .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
        .iROB_commit_en(iROB_commit_en), .iROB_commit_nick(iROB_commit_nick),
        .oDC_en(oDC_en), .oDC_ls(oDC_ls), .oDC_len(oDC_len), .oDC_addr(oDC_addr),
        .oDC_dt(oDC_dt), .iDC_en(iDC_en), .iDC_dt(iDC_dt),
        .oLSB_en(oLSB_en), .oLSB_nick(oLSB_nick), .oLSB_dt(oLSB_dt), .oFULL(oFULL)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] nick, input logic [3:0] q1,
                        input logic [31:0] v1, input logic [31:0] imm,
                        input logic [3:0] q2, input logic [31:0] v2);
        iDP_en = 1'b1; iDP_op = op; iDP_rd_nick = nick; iDP_imm = imm;
        iDP_rs1_nick = q1; iDP_rs1_dt = v1; iDP_rs2_nick = q2; iDP_rs2_dt = v2;
        tick();
        iDP_en = 1'b0;
    endtask

    // Waits (bounded) for the head load's request unless already seen, answers it, checks the broadcast.
    task automatic serve_load(input string tag, input bit seen, input logic [3:0] nick,
                              input logic [31:0] addr, input logic [2:0] len,
                              input logic [31:0] din, input logic [31:0] dexp);
        int n;
        n = 0;
        if (!seen) begin
            while (oDC_en !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            chk({tag, "_issue"}, 64'(oDC_en), 64'd1);
            chk({tag, "_addr"}, 64'(oDC_addr), 64'(addr));
            chk({tag, "_len"}, 64'(oDC_len), 64'(len));
            chk({tag, "_ls"}, 64'(oDC_ls), 64'd0);
        end
        iDC_en = 1'b1; iDC_dt = din;
        tick();
        iDC_en = 1'b0;
        chk({tag, "_lsb_en"}, 64'(oLSB_en), 64'd1);
        chk({tag, "_lsb_nick"}, 64'(oLSB_nick), 64'(nick));
        chk({tag, "_lsb_dt"}, 64'(oLSB_dt), 64'(dexp));
    endtask

    initial begin
        logic [3:0]  q_nick [$];
        logic [31:0] q_addr [$];
        logic [3:0]  nk;
        logic [31:0] ad;
        int          seq;
        bit          seen_st;
        bit          first;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_dc_en", 64'(oDC_en), 64'd0);
        chk("rst_lsb_en", 64'(oLSB_en), 64'd0);
        chk("rst_full", 64'(oFULL), 64'd0);
        chk("rst_count", 64'(dut.r_count), 64'd0);

        // Basic LW
        disp(OP_LW, 4'd1, 4'd0, 32'h100, 32'd4, 4'd0, 32'd0);
        tick();
        chk("lw_issue", 64'(oDC_en), 64'd1);
        chk("lw_addr", 64'(oDC_addr), 64'h104);
        chk("lw_len", 64'(oDC_len), 64'd4);
        chk("lw_ls", 64'(oDC_ls), 64'd0);
        iDC_en = 1'b1; iDC_dt = 32'hDEADBEEF;
        tick();
        iDC_en = 1'b0;
        chk("lw_lsb_en", 64'(oLSB_en), 64'd1);
        chk("lw_lsb_nick", 64'(oLSB_nick), 64'd1);
        chk("lw_lsb_dt", 64'(oLSB_dt), 64'hDEADBEEF);
        chk("lw_count", 64'(dut.r_count), 64'd0);

        // Extension: LB, LBU, LH, LHU in order
        disp(OP_LB, 4'd2, 4'd0, 32'h200, 32'd0, 4'd0, 32'd0);
        disp(OP_LBU, 4'd3, 4'd0, 32'h204, 32'd0, 4'd0, 32'd0);
        serve_load("lb", 1'b0, 4'd2, 32'h200, 3'd1, 32'h80, 32'hFFFFFF80);
        disp(OP_LH, 4'd10, 4'd0, 32'h208, 32'd0, 4'd0, 32'd0);
        serve_load("lbu", 1'b0, 4'd3, 32'h204, 3'd1, 32'h80, 32'h00000080);
        disp(OP_LHU, 4'd11, 4'd0, 32'h20C, 32'd0, 4'd0, 32'd0);
        serve_load("lh", 1'b0, 4'd10, 32'h208, 3'd2, 32'h8001, 32'hFFFF8001);
        serve_load("lhu", 1'b0, 4'd11, 32'h20C, 3'd2, 32'h8001, 32'h00008001);

        // Store waits for CDB operand and commit
        disp(OP_SW, 4'd3, 4'd0, 32'h300, 32'd8, 4'd5, 32'd0);
        iCDB_en = 2'b10; iCDB_nick = {4'd5, 4'd0}; iCDB_dt = {32'h55, 32'h0};
        tick();
        iCDB_en = 2'b00;
        seen_st = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (oDC_en) seen_st = 1'b1;
        end
        chk("sw_no_issue_before_commit", 64'(seen_st), 64'd0);
        iROB_commit_en = 1'b1; iROB_commit_nick = 4'd3;
        tick();
        iROB_commit_en = 1'b0;
        tick();
        chk("sw_issue", 64'(oDC_en), 64'd1);
        chk("sw_ls", 64'(oDC_ls), 64'd1);
        chk("sw_addr", 64'(oDC_addr), 64'h308);
        chk("sw_len", 64'(oDC_len), 64'd4);
        chk("sw_dt", 64'(oDC_dt), 64'h55);
        iDC_en = 1'b1;
        tick();
        iDC_en = 1'b0;
        chk("sw_no_lsb", 64'(oLSB_en), 64'd0);
        chk("sw_count", 64'(dut.r_count), 64'd0);

        // Flush keeps committed busy store, drops three loads
        disp(OP_SW, 4'd4, 4'd0, 32'h400, 32'd0, 4'd0, 32'hAA);
        iROB_commit_en = 1'b1; iROB_commit_nick = 4'd4;
        disp(OP_LW, 4'd5, 4'd9, 32'd0, 32'd0, 4'd0, 32'd0);
        iROB_commit_en = 1'b0;
        disp(OP_LW, 4'd6, 4'd9, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("clr_st_issue", 64'(oDC_en), 64'd1);
        chk("clr_st_ls", 64'(oDC_ls), 64'd1);
        chk("clr_st_dt", 64'(oDC_dt), 64'hAA);
        disp(OP_LW, 4'd7, 4'd9, 32'd0, 32'd0, 4'd0, 32'd0);
        chk("clr_pre_count", 64'(dut.r_count), 64'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", 64'(dut.r_count), 64'd1);
        iDC_en = 1'b1;
        tick();
        iDC_en = 1'b0;
        chk("clr_st_done_lsb", 64'(oLSB_en), 64'd0);
        chk("clr_st_done_count", 64'(dut.r_count), 64'd0);
        tick(); tick();
        chk("clr_quiet_lsb", 64'(oLSB_en), 64'd0);
        chk("clr_quiet_dc", 64'(oDC_en), 64'd0);

        // Flush with outstanding load: late completion dropped
        disp(OP_LW, 4'd8, 4'd0, 32'h500, 32'd0, 4'd0, 32'd0);
        tick();
        chk("drop_issue", 64'(oDC_en), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("drop_count", 64'(dut.r_count), 64'd0);
        disp(OP_LW, 4'd9, 4'd0, 32'h600, 32'd0, 4'd0, 32'd0);
        iDC_en = 1'b1; iDC_dt = 32'h1234;
        tick();
        iDC_en = 1'b0;
        chk("drop_no_lsb", 64'(oLSB_en), 64'd0);
        chk("drop_keep_count", 64'(dut.r_count), 64'd1);
        serve_load("after_drop", 1'b0, 4'd9, 32'h600, 3'd4, 32'h77, 32'h77);

        // Fill to 15, interleave pops/dispatches across wraps, then drain
        seq = 1;
        for (int t = 1; t <= 15; t++) begin
            disp(OP_LW, 4'(t), 4'd0, 32'(seq * 16), 32'd0, 4'd0, 32'd0);
            q_nick.push_back(4'(t));
            q_addr.push_back(32'(seq * 16));
            seq++;
            if (t == 2) begin
                chk("wrap_first_issue", 64'(oDC_en), 64'd1);
                chk("wrap_first_addr", 64'(oDC_addr), 64'd16);
            end
            if (t == 14) chk("full_at_14", 64'(oFULL), 64'd0);
        end
        chk("full_at_15", 64'(oFULL), 64'd1);
        chk("count_15", 64'(dut.r_count), 64'd15);
        first = 1'b1;
        for (int r = 0; r < 20; r++) begin
            nk = q_nick.pop_front();
            ad = q_addr.pop_front();
            serve_load("wrap", first, nk, ad, 3'd4, 32'hA0000000 | ad, 32'hA0000000 | ad);
            first = 1'b0;
            disp(OP_LW, nk, 4'd0, 32'(seq * 16), 32'd0, 4'd0, 32'd0);
            q_nick.push_back(nk);
            q_addr.push_back(32'(seq * 16));
            seq++;
            chk("full_wrap", 64'(oFULL), 64'd1);
        end
        while (q_nick.size() > 0) begin
            nk = q_nick.pop_front();
            ad = q_addr.pop_front();
            serve_load("drain", 1'b0, nk, ad, 3'd4, 32'hA0000000 | ad, 32'hA0000000 | ad);
        end
        chk("drain_count", 64'(dut.r_count), 64'd0);
        chk("drain_full", 64'(oFULL), 64'd0);

        // Same-cycle CDB forwarding at dispatch, then reset mid-request
        iCDB_en = 2'b01; iCDB_nick = {4'd0, 4'd7}; iCDB_dt = {32'h0, 32'h700};
        disp(OP_LW, 4'd7, 4'd7, 32'hBAD, 32'h10, 4'd0, 32'd0);
        iCDB_en = 2'b00;
        tick();
        chk("fwd_issue", 64'(oDC_en), 64'd1);
        chk("fwd_addr", 64'(oDC_addr), 64'h710);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_dc_en", 64'(oDC_en), 64'd0);
        chk("rst2_dc_addr", 64'(oDC_addr), 64'd0);
        chk("rst2_lsb_en", 64'(oLSB_en), 64'd0);
        chk("rst2_full", 64'(oFULL), 64'd0);
        chk("rst2_count", 64'(dut.r_count), 64'd0);
        tick();
        chk("rst2_idle", 64'(oDC_en), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsb_queue.md
Name: lsb_queue

Overview:
- Parametrised in-order load/store queue; successor to the indexed store/load buffer.
- Sits between dispatch, ROB, the CDB and the data cache.
- Holds memory ops in a circular FIFO and snoops CDB_N result channels plus its own result.
- Issues loads at head when ready; issues stores only after ROB commit; sign-extends load data; on flush keeps committed stores.

Parameters:
DEPTH, 16, queue entries (power of two)
IDX_W, 4, log2(DEPTH)
NICK_W, 4, ROB tag width; tag 0 = operand value valid
DATA_W, 32, data width
ADDR_W, 32, address width
OP_W, 6, opcode width (config.v op defines)
CDB_N, 2, external CDB snoop channels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; state frozen when low
clr  in  1  misprediction flush
iDP_en  in  1  dispatch valid (only memory ops asserted)
iDP_op  in  OP_W  LB/LBU/LH/LHU/LW/SB/SH/SW
iDP_imm  in  DATA_W  offset
iDP_rd_nick  in  NICK_W  ROB tag of this op
iDP_rs1_nick / iDP_rs2_nick  in  NICK_W each  producer tags (0 = ready)
iDP_rs1_dt / iDP_rs2_dt  in  DATA_W each  operand values when tag 0
iCDB_en  in  CDB_N  per-channel broadcast valid
iCDB_nick  in  CDB_N*NICK_W  packed tags, channel k at [k*NICK_W +: NICK_W]
iCDB_dt  in  CDB_N*DATA_W  packed data
iROB_commit_en  in  1  store commit pulse
iROB_commit_nick  in  NICK_W  committed store tag
oDC_en  out  1  one-cycle cache request pulse
oDC_ls  out  1  0 load, 1 store
oDC_len  out  3  1/2/4 bytes
oDC_addr  out  ADDR_W  rs1+imm
oDC_dt  out  DATA_W  store data
iDC_en  in  1  cache completion pulse
iDC_dt  in  DATA_W  load data, raw zero-extended
oLSB_en  out  1  load result broadcast pulse
oLSB_nick  out  NICK_W  result tag
oLSB_dt  out  DATA_W  extended result
oFULL  out  1  registered almost-full

Behaviour:
- Reset, and after any cycle with rst high: head = tail = count = 0; all valid/committed/busy/drop flags 0; every output 0.
- Dispatch: iDP_en writes entry at tail next cycle; tail++ mod DEPTH; count++.
  - Operand ready if tag 0, or tag matches a same-cycle iCDB/oLSB broadcast; value is then captured from that broadcast.
- Snoop: each cycle, every valid entry with a non-ready operand compares against all CDB_N channels and the internal oLSB; on match, captures data and marks ready. On multiple matches the lowest channel index wins; internal oLSB ranks last.
- Commit: on iROB_commit_en, the store whose tag equals iROB_commit_nick sets committed = 1.
- Issue: at most one outstanding request (busy); considers head entry only.
  - Load head issues when rs1 ready.
  - Store head issues when rs1 ready, rs2 ready and committed.
  - Issue drives oDC_en for 1 cycle with addr = rs1+imm (mod 2^ADDR_W) and sets busy.
  - Length: B/BU/SB = 1, H/HU/SH = 2, W/SW = 4.
- Completion: iDC_en clears busy and pops head.
  - Load: next cycle oLSB_en = 1, nick = tag, dt = LB/LH sign-extended, LBU/LHU zero-extended, LW raw.
  - Store: no broadcast.
- Pop and dispatch in the same cycle: count unchanged.
- oFULL registered high when next count >= DEPTH-1, giving one cycle of dispatch slack. Dispatch while count == DEPTH is a protocol error and does not write.
- clr (rst has priority):
  - Committed stores form a prefix from head; tail is reset to the first uncommitted entry; all other entries are invalidated; count is recomputed.
  - An outstanding store completes normally.
  - An outstanding load sets drop: its iDC_en pops nothing and broadcasts nothing.
  - Same-cycle iDP_en is ignored.
  - A same-cycle commit still applies before the truncation.
- Wrap-around: head and tail are IDX_W bits and wrap naturally; full is distinguished by count.
- Tags are unique in flight; tag 0 is never assigned to an op.

Test Plan:
- LW, rs1_nick 0, rs1 = 0x100, imm = 4 -> oDC_en next cycle, addr 0x104, len 4. iDC_dt 0xDEADBEEF -> oLSB_en with dt 0xDEADBEEF, tag echoed, queue empty.
- LB then LBU with iDC_dt 0x80 -> broadcasts 0xFFFFFF80 and 0x00000080 in order.
- SW tag 3, rs2_nick 5, CDB channel 1 broadcasts tag 5 data 0x55 -> no oDC_en until commit tag 3. Then store addr issues with dt 0x55 and oLSB stays 0.
- Committed SW at head (busy) plus 3 uncommitted loads, clr -> count 1, store completes, then queue empty, no oLSB pulses. Also: clr with outstanding load -> late iDC_en is dropped.
- Fill DEPTH entries with interleaved pops, wrapping tail twice -> oFULL at count 15, FIFO order preserved across wrap, count returns to 0.
- Dispatch with rs1_nick 7 while iCDB channel 0 broadcasts tag 7 -> entry issues without waiting for another broadcast. rst mid-request -> all outputs 0 next cycle.
